// File: rtl/conv_pkg.sv
// Shared types and constants for the serial receive deserializer family.
package conv_pkg;

   localparam int C4_PERIOD_NS  = 244;
   localparam int DEF_NBITS     = 32;
   localparam int DEF_START_DLY = 2;
   localparam int DEF_BIT_CYC   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/f0_edge_det.sv
// Registers the active-low frame sync and flags its falling edge as a frame start.
module f0_edge_det (
   input  logic c4,
   input  logic reset_in_rg,
   input  logic f0,
   output logic frame_start
);

   logic f0_q, f0_d;
   logic armed_q, armed_d;

   // armed_q only rises once f0 is really sampled high, so a sync held low
   // through reset cannot fake an edge against the reset value of f0_q.
   always_comb begin
      f0_d    = f0;
      armed_d = armed_q | f0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values computed before the edge regardless of block order.
   always_ff @(posedge c4) begin
      if (reset_in_rg) begin
         f0_q    <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         f0_q    <= f0_d;
         armed_q <= armed_d;
      end
   end

   assign frame_start = armed_q & f0_q & ~f0;

endmodule

// File: rtl/st_rx_deser.sv
// Frame-synchronised serial receiver: captures NBITS MSB-first bits per frame
// and hands completed words to the CPU through a level interrupt.
module st_rx_deser
   import conv_pkg::*;
#(
   parameter int NBITS     = DEF_NBITS,
   parameter int START_DLY = DEF_START_DLY,
   parameter int BIT_CYC   = DEF_BIT_CYC
) (
   input  logic             c4,
   input  logic             reset_in_rg,
   input  logic             f0,
   input  logic             data_from_dt,
   input  logic             int_ack,
   output logic [NBITS-1:0] rx_word,
   output logic             cpu_int,
   output logic             clk_en_rx,
   output logic             overrun,
   output logic             frame_err
);

   localparam int BW = $clog2(NBITS);

   logic frame_start;

   f0_edge_det u_f0_edge_det (
      .c4          (c4),
      .reset_in_rg (reset_in_rg),
      .f0          (f0),
      .frame_start (frame_start)
   );

   rx_state_t        state_q, state_d;
   logic [3:0]       dly_cnt_q, dly_cnt_d;
   logic [3:0]       cyc_cnt_q, cyc_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [NBITS-1:0] sr_q, sr_d;
   logic [NBITS-1:0] rx_word_q, rx_word_d;
   logic             cpu_int_q, cpu_int_d;
   logic             clk_en_q, clk_en_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             load;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      dly_cnt_d   = dly_cnt_q;
      cyc_cnt_d   = cyc_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      rx_word_d   = rx_word_q;
      overrun_d   = overrun_q;
      frame_err_d = 1'b0;
      load        = 1'b0;

      if (frame_start) begin
         frame_err_d = (state_q != ST_IDLE);
         state_d     = ST_DELAY;
         dly_cnt_d   = 4'(START_DLY - 1);
         cyc_cnt_d   = '0;
         bit_cnt_d   = '0;
         sr_d        = '0;
      end else begin
         case (state_q)
            ST_DELAY: begin
               // Bit 0 is taken on the cycle the delay expires.
               if (dly_cnt_q == 4'd0) begin
                  sr_d      = {sr_q[NBITS-2:0], data_from_dt};
                  bit_cnt_d = BW'(1);
                  cyc_cnt_d = 4'(BIT_CYC - 1);
                  state_d   = ST_SHIFT;
               end else begin
                  dly_cnt_d = dly_cnt_q - 4'd1;
               end
            end
            ST_SHIFT: begin
               if (cyc_cnt_q == 4'd0) begin
                  sr_d      = {sr_q[NBITS-2:0], data_from_dt};
                  cyc_cnt_d = 4'(BIT_CYC - 1);
                  if (bit_cnt_q == BW'(NBITS - 1)) begin
                     bit_cnt_d = '0;
                     state_d   = ST_DONE;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end else begin
                  cyc_cnt_d = cyc_cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               load    = ~cpu_int_q | int_ack;
               state_d = ST_IDLE;
               if (load) rx_word_d = sr_q;
               else      overrun_d = 1'b1;
            end
            default: ;
         endcase
      end

      if (load)                       cpu_int_d = 1'b1;
      else if (int_ack && cpu_int_q)  cpu_int_d = 1'b0;
      else                            cpu_int_d = cpu_int_q;

      if (int_ack && cpu_int_q) overrun_d = 1'b0;

      clk_en_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge c4) begin
      if (reset_in_rg) begin
         state_q     <= ST_IDLE;
         dly_cnt_q   <= '0;
         cyc_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         sr_q        <= '0;
         rx_word_q   <= '0;
         cpu_int_q   <= 1'b0;
         clk_en_q    <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dly_cnt_q   <= dly_cnt_d;
         cyc_cnt_q   <= cyc_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         rx_word_q   <= rx_word_d;
         cpu_int_q   <= cpu_int_d;
         clk_en_q    <= clk_en_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_word   = rx_word_q;
   assign cpu_int   = cpu_int_q;
   assign clk_en_rx = clk_en_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule
